// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode set and FSM states shared by alu_seq and its bench.
// Opcode encoding is the 16-entry command set of the original 8-bit ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MUL  = 4'd2,
    DIV  = 4'd3,
    INV  = 4'd4,
    INC  = 4'd5,
    DEC  = 4'd6,
    SHL  = 4'd7,
    SHR  = 4'd8,
    AND  = 4'd9,
    OR   = 4'd10,
    NAND = 4'd11,
    NOR  = 4'd12,
    XOR  = 4'd13,
    XNOR = 4'd14,
    MOD  = 4'd15
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_div_op(input alu_cmd_e c);
    return (c == DIV) || (c == MOD);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// alu_seq_div: restoring divider, one quotient bit per cycle over WIDTH cycles.
// Latency: done is high during the WIDTH-th cycle after start; quo/rem then show the final values.
// Backpressure: none; quo/rem stay frozen after done until the next start.
module alu_seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvsr, q_r, r_r;
  logic [WIDTH:0]   shifted;
  logic             ge, last;
  logic [WIDTH-1:0] q_step, r_step;

  // Dividend shifts out of q_r MSB-first while quotient bits shift in at the bottom.
  assign shifted = {r_r, q_r[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvsr};
  // Partial remainder stays below dvsr, so the W-bit difference is exact when ge.
  assign r_step  = ge ? (shifted[WIDTH-1:0] - dvsr) : shifted[WIDTH-1:0];
  assign q_step  = {q_r[WIDTH-2:0], ge};
  assign last    = (cnt == CW'(WIDTH - 1));

  assign done = busy && last;
  assign quo  = busy ? q_step : q_r;
  assign rem  = busy ? r_step : r_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      dvsr <= '0;
      q_r  <= '0;
      r_r  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      dvsr <= divisor;
      q_r  <= dividend;
      r_r  <= '0;
    end else if (busy) begin
      q_r <= q_step;
      r_r <= r_step;
      cnt <= cnt + CW'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with flags; define ALU_DIV_EN to build the iterative DIV/MOD divider.
// Latency: 1 cycle; WIDTH+1 cycles for DIV/MOD with nonzero divisor when ALU_DIV_EN is defined.
// Backpressure: in_ready low while dividing or while a stalled result is not taken; outputs hold while stalled.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_err
);

  state_e           state;
  alu_cmd_e         cmd;
  logic             accept;
  logic [RES_W-1:0] ax, bx, res;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] lw;
  logic             narrow, res_c, res_e;

  assign cmd      = alu_cmd_e'(command);
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign ax       = {{WIDTH{1'b0}}, a};
  assign bx       = {{WIDTH{1'b0}}, b};

`ifdef ALU_DIV_EN
  logic             div_long, div_done, op_mod;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [RES_W-1:0] div_res;

  assign div_long = is_div_op(cmd) && (b != '0);
  assign div_res  = {{WIDTH{1'b0}}, op_mod ? div_rem : div_quo};

  alu_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && div_long),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );
`endif

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    res    = '0;
    lw     = '0;
    narrow = 1'b1;
    res_c  = 1'b0;
    res_e  = 1'b0;
    case (cmd)
      ADD: begin res = {{(WIDTH-1){1'b0}}, sum}; res_c = sum[WIDTH]; narrow = 1'b0; end
      SUB: begin res = ax - bx; res_c = (a < b); narrow = 1'b0; end
      MUL: begin res = ax * bx; narrow = 1'b0; end
      INC: begin lw = b + WIDTH'(1); res_c = &b; end
      DEC: begin lw = b - WIDTH'(1); res_c = ~|b; end
      SHL: begin lw = {a[WIDTH-2:0], 1'b0}; res_c = a[WIDTH-1]; end
      SHR: begin lw = {1'b0, b[WIDTH-1:1]}; res_c = b[0]; end
      INV:  lw = ~a;
      AND:  lw = a & b;
      OR:   lw = a | b;
      NAND: lw = ~(a & b);
      NOR:  lw = ~(a | b);
      XOR:  lw = a ^ b;
      XNOR: lw = ~(a ^ b);
      // Only the zero-divisor case completes here when the divider exists.
      DIV: begin
        res_e = 1'b1;
`ifdef ALU_DIV_EN
        lw = '1;
`endif
      end
      MOD: begin
        res_e = 1'b1;
`ifdef ALU_DIV_EN
        lw = a;
`endif
      end
      default: lw = '0;
    endcase
    if (narrow) res = {{WIDTH{1'b0}}, lw};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out        <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_err   <= 1'b0;
      out_valid  <= 1'b0;
`ifdef ALU_DIV_EN
      op_mod     <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
`ifdef ALU_DIV_EN
            if (div_long) begin
              state  <= ST_DIV;
              op_mod <= (cmd == MOD);
            end else
`endif
            begin
              out        <= res;
              flag_zero  <= (res == '0);
              flag_carry <= res_c;
              flag_err   <= res_e;
              out_valid  <= 1'b1;
            end
          end
        end
`ifdef ALU_DIV_EN
        ST_DIV: begin
          if (div_done) begin
            if (out_valid && !out_ready) begin
              state <= ST_HOLD;
            end else begin
              out        <= div_res;
              flag_zero  <= (div_res == '0);
              flag_carry <= 1'b0;
              flag_err   <= 1'b0;
              out_valid  <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (!out_valid || out_ready) begin
            out        <= div_res;
            flag_zero  <= (div_res == '0);
            flag_carry <= 1'b0;
            flag_err   <= 1'b0;
            out_valid  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random operations checked through a scoreboard against an arithmetic model.
// Honours ALU_DIV_EN the same way the design does.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W   = 8;
  localparam int RW  = 2 * W;
  localparam int TMO = 400;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [3:0]    command;
  logic [RW-1:0] out;
  logic          flag_zero, flag_carry, flag_err;

  typedef struct packed {
    logic [RW-1:0] out;
    logic          z;
    logic          c;
    logic          e;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass = 0;
  int   total = 0;
  int   last_wait = 0;
  bit   rand_rdy = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .command    (command),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_err   (flag_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input alu_cmd_e c, input longint x, input longint y);
    exp_t   e;
    longint m, mr, r;
    m  = (longint'(1) << W) - 1;
    mr = (longint'(1) << RW) - 1;
    e  = '0;
    r  = 0;
    e.lat = 1;
    case (c)
      ADD:  begin r = x + y; e.c = (r > m); end
      SUB:  begin r = (x - y) & mr; e.c = (x < y); end
      MUL:  r = x * y;
      INV:  r = m - x;
      INC:  begin r = (y + 1) & m; e.c = (y == m); end
      DEC:  begin r = (y - 1) & m; e.c = (y == 0); end
      SHL:  begin r = (x * 2) & m; e.c = (x > m / 2); end
      SHR:  begin r = y / 2; e.c = ((y % 2) == 1); end
      AND:  r = x & y;
      OR:   r = x | y;
      NAND: r = m - (x & y);
      NOR:  r = m - (x | y);
      XOR:  r = x ^ y;
      XNOR: r = m - (x ^ y);
      DIV, MOD: begin
`ifdef ALU_DIV_EN
        if (y == 0) begin
          r = (c == DIV) ? m : x;
          e.e = 1'b1;
        end else begin
          r = (c == DIV) ? x / y : x % y;
          e.lat = W + 1;
        end
`else
        r = 0;
        e.e = 1'b1;
`endif
      end
      default: r = 0;
    endcase
    e.out = r[RW-1:0];
    e.z   = (r == 0);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the rising edge that takes the offer.
  task automatic send(input alu_cmd_e c, input longint x, input longint y, input bit push);
    int   n;
    exp_t e;
    n = 0;
    in_valid = 1;
    a = x[W-1:0];
    b = y[W-1:0];
    command = c;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    @(negedge clk);
    while (!in_ready && n < TMO) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", n);
    end else if (push) begin
      e = model(c, x, y);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  // Monitor: pops on each newly presented result, checks stability while stalled.
  initial begin : monitor
    exp_t          e;
    logic          prev_vld, prev_hs;
    logic [RW+2:0] held;
    prev_vld = 0;
    prev_hs  = 0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld = 0;
        prev_hs  = 0;
      end else begin
        if (out_valid && (!prev_vld || prev_hs)) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: got out=%0h with nothing outstanding", out);
          end else begin
            e = sb.pop_front();
            chk("result", 32'({flag_zero, flag_carry, flag_err, out}), 32'({e.z, e.c, e.e, e.out}));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          held = {flag_zero, flag_carry, flag_err, out};
        end else if (prev_vld && !prev_hs) begin
          chk("stall_hold", 32'({out_valid, flag_zero, flag_carry, flag_err, out}), 32'({1'b1, held}));
        end
        prev_vld = out_valid;
        prev_hs  = out_valid && out_ready;
      end
    end
  end

  initial begin : stim
    logic [3:0] r4;
    longint     x, y;
    int         n;
    rst = 1; in_valid = 0; a = '0; b = '0; command = 4'd0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({flag_zero, flag_carry, flag_err}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    send(ADD, 200, 100, 1);
    send(SUB, 5, 7, 1);
    send(XOR, 'hAA, 'hAA, 1);
    send(DIV, 200, 7, 1);
`ifdef ALU_DIV_EN
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("div_in_ready_low", 32'(in_ready), 32'd0);
    end
`endif
    send(MOD, 200, 7, 1);
    send(DIV, 9, 0, 1);
    send(MOD, 9, 0, 1);
    idle(2);

    // Back-pressure, then drain and accept in the same cycle.
    out_ready = 0;
    send(MUL, 15, 15, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(ADD, 1, 1, 1);
    chk("drain_and_accept_same_cycle", 32'(last_wait), 32'd0);
    idle(2);

    // Reset during the fourth divider cycle discards the division.
`ifdef ALU_DIV_EN
    send(DIV, 100, 3, 0);
`else
    send(DIV, 100, 3, 1);
`endif
    idle(3);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({out_valid, out}), 32'd0);
    end
    @(posedge clk); #1;
    send(ADD, 1, 2, 1);
    idle(2);

    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      r4 = 4'($urandom_range(0, 15));
      x  = longint'($urandom_range(0, (1 << W) - 1));
      y  = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(0, (1 << W) - 1));
      send(alu_cmd_e'(r4), x, y, 1);
      idle($urandom_range(0, 2));
    end
    rand_rdy = 0;
    out_ready = 1;

    n = 0;
    while (sb.size() != 0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
